cfo_corr_mc: RTL

//  Multi-lane carrier-frequency-offset corrector for the RX datapath; successor to the single-lane CFO corrector.

---
 rtl/cfo_corr_mc.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cfo_corr_mc.sv
`default_nettype none
// ============================================================================
// Module   : cfo_corr_mc
// Brief    : Multi-lane NCO rotator for RX carrier-frequency-offset removal,
//            4-stage pipeline under a global AXI-stream stall.
//            Define CFO_CORR_ROUND_EN for round-half-up scaling (default floor).
// Revision : 1.0
// ============================================================================
module cfo_corr_mc #(
   parameter int DATA_WIDTH    = 16,
   parameter int PHASE_WIDTH   = 24,
   parameter int SIN_COS_WIDTH = 16,
   parameter int LUT_AW        = 10,
   parameter int NUM_CH        = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                run_rx,
   input  logic                                frame_rst,
   input  logic                                cfg_valid,
   input  logic [NUM_CH*PHASE_WIDTH-1:0]       phase_cfo,
   input  logic [NUM_CH*2*DATA_WIDTH-1:0]      in_tdata,
   input  logic                                in_tvalid,
   input  logic                                in_tlast,
   output logic                                in_tready,
   output logic [NUM_CH*2*DATA_WIDTH-1:0]      out_tdata,
   output logic                                out_tvalid,
   output logic                                out_tlast,
   input  logic                                out_tready,
   output logic [SIN_COS_WIDTH-1:0]            sin,
   output logic [SIN_COS_WIDTH-1:0]            cos
);

   localparam int DW        = DATA_WIDTH;
   localparam int PW        = PHASE_WIDTH;
   localparam int SCW       = SIN_COS_WIDTH;
   localparam int PROD_W    = DW + SCW;
   localparam int SUM_W     = DW + SCW + 1;
   localparam int ROM_DEPTH = 1 << LUT_AW;
   localparam int QTR       = ROM_DEPTH / 4;
   localparam int AMP       = (1 << (SCW - 1)) - 1;

   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 <<< (DW - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO = -SUM_W'(1 <<< (DW - 1));
`ifdef CFO_CORR_ROUND_EN
   localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) <<< (SCW - 2);
`endif

   // sin over [0, pi/2] in Q30 by a Taylor series, evaluated only at elaboration
   function automatic longint sin_quadrant(input int m);
      longint x, term, acc, r;
      x    = (longint'(m) * 64'sd1686629713) / longint'(QTR);
      term = x;
      acc  = x;
      for (int k = 1; k <= 6; k++) begin
         term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      r = (acc * longint'(AMP) + (64'sd1 <<< 29)) >>> 30;
      if (r > longint'(AMP)) r = longint'(AMP);
      return r;
   endfunction

   function automatic logic [SCW-1:0] sin_entry(input int a);
      int     q, r;
      longint v;
      q = a / QTR;
      r = a % QTR;
      v = (q == 1 || q == 3) ? sin_quadrant(QTR - r) : sin_quadrant(r);
      if (q >= 2) v = -v;
      return SCW'(v);
   endfunction

   function automatic logic [DW-1:0] scale_sat(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] r;
`ifdef CFO_CORR_ROUND_EN
      r = (s + RND) >>> (SCW - 1);
`else
      r = s >>> (SCW - 1);
`endif
      if (r > SAT_HI)      return SAT_HI[DW-1:0];
      else if (r < SAT_LO) return SAT_LO[DW-1:0];
      return r[DW-1:0];
   endfunction

   // Full-wave sine table; cosine reads the same table a quarter turn ahead
   logic [SCW-1:0] rom [ROM_DEPTH];
   for (genvar a = 0; a < ROM_DEPTH; a++) begin : g_rom
      localparam logic [SCW-1:0] ENTRY = sin_entry(a);
      assign rom[a] = ENTRY;
   end

   logic en, accept;
   logic v_s0, v_s1, v_s2;
   logic last_s0, last_s1, last_s2;
   logic [SCW-1:0] lane0_sin, lane0_cos, dbg_sin_s2, dbg_cos_s2;

   assign en        = ~out_tvalid | out_tready;
   assign in_tready = run_rx & en;
   assign accept    = in_tvalid & in_tready;

   always_ff @(posedge clk) begin
      if (reset) begin
         v_s0       <= 1'b0;
         v_s1       <= 1'b0;
         v_s2       <= 1'b0;
         last_s0    <= 1'b0;
         last_s1    <= 1'b0;
         last_s2    <= 1'b0;
         out_tvalid <= 1'b0;
         out_tlast  <= 1'b0;
         dbg_sin_s2 <= '0;
         dbg_cos_s2 <= '0;
         sin        <= '0;
         cos        <= '0;
      end else if (en) begin
         v_s0       <= accept;
         last_s0    <= in_tlast & accept;
         v_s1       <= v_s0;
         last_s1    <= last_s0;
         v_s2       <= v_s1;
         last_s2    <= last_s1;
         dbg_sin_s2 <= lane0_sin;
         dbg_cos_s2 <= lane0_cos;
         out_tvalid <= v_s2;
         out_tlast  <= last_s2;
         sin        <= dbg_sin_s2;
         cos        <= dbg_cos_s2;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      logic [PW-1:0]            inc, ph;
      logic [LUT_AW-1:0]        idx_s0, cos_idx;
      logic signed [DW-1:0]     i_s0, q_s0, i_s1, q_s1, out_i, out_q;
      logic signed [SCW-1:0]    sin_s1, cos_s1;
      logic signed [PROD_W-1:0] p_ic, p_qs, p_is, p_qc;
      logic signed [SUM_W-1:0]  sum_i, sum_q;

      // A same-cycle reload still accumulates with the old increment
      always_ff @(posedge clk) begin
         if (reset) begin
            inc <= '0;
            ph  <= '0;
         end else begin
            if (cfg_valid) inc <= phase_cfo[k*PW +: PW];
            if (!run_rx)     ph <= '0;
            else if (accept) ph <= (frame_rst && in_tlast) ? '0 : ph + inc;
         end
      end

      assign cos_idx = idx_s0 + LUT_AW'(QTR);
      assign sum_i   = SUM_W'(p_ic) - SUM_W'(p_qs);
      assign sum_q   = SUM_W'(p_is) + SUM_W'(p_qc);

      always_ff @(posedge clk) begin
         if (reset) begin
            idx_s0 <= '0;
            i_s0   <= '0;
            q_s0   <= '0;
            i_s1   <= '0;
            q_s1   <= '0;
            sin_s1 <= '0;
            cos_s1 <= '0;
            p_ic   <= '0;
            p_qs   <= '0;
            p_is   <= '0;
            p_qc   <= '0;
            out_i  <= '0;
            out_q  <= '0;
         end else if (en) begin
            idx_s0 <= ph[PW-1 -: LUT_AW];
            i_s0   <= in_tdata[k*2*DW+DW +: DW];
            q_s0   <= in_tdata[k*2*DW +: DW];
            i_s1   <= i_s0;
            q_s1   <= q_s0;
            sin_s1 <= rom[idx_s0];
            cos_s1 <= rom[cos_idx];
            p_ic   <= PROD_W'(i_s1) * PROD_W'(cos_s1);
            p_qs   <= PROD_W'(q_s1) * PROD_W'(sin_s1);
            p_is   <= PROD_W'(i_s1) * PROD_W'(sin_s1);
            p_qc   <= PROD_W'(q_s1) * PROD_W'(cos_s1);
            out_i  <= scale_sat(sum_i);
            out_q  <= scale_sat(sum_q);
         end
      end

      assign out_tdata[k*2*DW +: 2*DW] = {out_i, out_q};

      if (k == 0) begin : g_dbg
         assign lane0_sin = sin_s1;
         assign lane0_cos = cos_s1;
      end
   end

endmodule
`default_nettype wire
